// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives a req/ack data-memory port from the EX/MEM fields and returns extended load data.
// Optional bus-timeout abort is enabled with `define LSU_TIMEOUT_EN.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  func3m,
    input  logic        memwr_sgnm,
    input  logic        memrd_sgnm,
    input  logic [31:0] alu_resultm,
    input  logic [31:0] rd_final2m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_m,
    output logic [31:0] load_datam,
    output logic        misalign_m,
    output logic        bus_err_m
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYC)) begin : g_bad_cfg
        $error("mem_stage_lsu: CNT_W too narrow for TIMEOUT_CYC");
    end

    state_t      state;
    logic [2:0]  func3_q;
    logic [1:0]  off_q;
    logic        load_q;

    logic        access;
    logic        misal;
    logic        issue;
    logic        done;
    logic        timeout_hit;
    logic [2:0]  cur_func3;
    logic [1:0]  cur_off;
    logic        cur_load;

    function automatic logic [31:0] extract(input logic [2:0]  f3,
                                            input logic [1:0]  off,
                                            input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = rdata >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            F3_B:    extract = {{24{b[7]}}, b};
            F3_BU:   extract = {24'd0, b};
            F3_H:    extract = {{16{h[15]}}, h};
            F3_HU:   extract = {16'd0, h};
            default: extract = rdata;
        endcase
    endfunction

    // Illegal funct3 encodings are folded into the misaligned path so they never reach the bus.
    always_comb begin
        misal = 1'b1;
        case (func3m)
            F3_B, F3_BU: misal = 1'b0;
            F3_H, F3_HU: misal = alu_resultm[0];
            F3_W:        misal = (alu_resultm[1:0] != 2'b00);
            default:     misal = 1'b1;
        endcase
    end

    assign access = memwr_sgnm | memrd_sgnm;
    assign issue  = (state == S_IDLE) && access && !misal;

`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    assign timeout_hit = (state == S_WAIT) && !dmem_ack && (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
    assign bus_err_m   = 1'b0;
`endif

    // The aborting cycle drops the request so stall_m = dmem_req & ~dmem_ack stays exact.
    assign dmem_req = issue || ((state == S_WAIT) && !timeout_hit);
    assign stall_m  = dmem_req && !dmem_ack;
    assign done     = dmem_req && dmem_ack;

    // Same-cycle completion in IDLE uses the live fields; WAIT uses what was captured at issue.
    assign cur_func3 = (state == S_WAIT) ? func3_q : func3m;
    assign cur_off   = (state == S_WAIT) ? off_q   : alu_resultm[1:0];
    assign cur_load  = (state == S_WAIT) ? load_q  : !memwr_sgnm;

    assign dmem_we   = memwr_sgnm;
    assign dmem_addr = {alu_resultm[31:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = rd_final2m;
        if (memwr_sgnm) begin
            case (func3m[1:0])
                2'b00: begin
                    dmem_be    = 4'b0001 << alu_resultm[1:0];
                    dmem_wdata = {4{rd_final2m[7:0]}};
                end
                2'b01: begin
                    dmem_be    = alu_resultm[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata = {2{rd_final2m[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = rd_final2m;
                end
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            func3_q    <= 3'b000;
            off_q      <= 2'b00;
            load_q     <= 1'b0;
            load_datam <= 32'd0;
            misalign_m <= 1'b0;
        end else begin
            misalign_m <= (state == S_IDLE) && access && misal;

            case (state)
                S_IDLE: begin
                    if (issue && !dmem_ack) begin
                        state   <= S_WAIT;
                        func3_q <= func3m;
                        off_q   <= alu_resultm[1:0];
                        load_q  <= !memwr_sgnm;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack || timeout_hit)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (done && cur_load)
                load_datam <= extract(cur_func3, cur_off, dmem_rdata);
            else if (timeout_hit)
                load_datam <= 32'd0;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bus_err_m <= 1'b0;
        end else begin
            bus_err_m <= timeout_hit;
            if ((state == S_WAIT) && !dmem_ack && !timeout_hit)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (default build, timeout feature disabled).
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  func3m;
    logic        memwr_sgnm;
    logic        memrd_sgnm;
    logic [31:0] alu_resultm;
    logic [31:0] rd_final2m;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_m;
    logic [31:0] load_datam;
    logic        misalign_m;
    logic        bus_err_m;

    int total = 0;
    int bad   = 0;

    mem_stage_lsu dut (
        .clk         (clk),
        .rst         (rst),
        .func3m      (func3m),
        .memwr_sgnm  (memwr_sgnm),
        .memrd_sgnm  (memrd_sgnm),
        .alu_resultm (alu_resultm),
        .rd_final2m  (rd_final2m),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .stall_m     (stall_m),
        .load_datam  (load_datam),
        .misalign_m  (misalign_m),
        .bus_err_m   (bus_err_m)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic ack, input logic [31:0] rdata);
        memwr_sgnm  = wr;
        memrd_sgnm  = rd;
        func3m      = f3;
        alu_resultm = addr;
        rd_final2m  = wd;
        dmem_ack    = ack;
        dmem_rdata  = rdata;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        int stall_cnt;
        rst = 1'b1;
        idle();
        adv();
        adv();
        rst = 1'b0;
        settle();
        check("rst_req",      {31'd0, dmem_req},   32'd0);
        check("rst_stall",    {31'd0, stall_m},    32'd0);
        check("rst_load",     load_datam,          32'd0);
        check("rst_misalign", {31'd0, misalign_m}, 32'd0);
        check("rst_buserr",   {31'd0, bus_err_m},  32'd0);

        // LW 0x100 with same-cycle ack
        adv();
        drive(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF);
        settle();
        check("lw_req",   {31'd0, dmem_req}, 32'd1);
        check("lw_stall", {31'd0, stall_m},  32'd0);
        check("lw_addr",  dmem_addr,         32'h100);
        check("lw_be",    {28'd0, dmem_be},  32'hF);
        check("lw_we",    {31'd0, dmem_we},  32'd0);
        adv();
        idle();
        settle();
        check("lw_data", load_datam, 32'hDEADBEEF);

        // LB 0x103, ack after three stalled cycles
        adv();
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 1'b0, 32'h0);
            settle();
            if (stall_m) stall_cnt++;
            adv();
        end
        check("lb_stall_cycles", stall_cnt, 32'd3);
        drive(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 1'b1, 32'h80123456);
        settle();
        check("lb_ack_stall", {31'd0, stall_m}, 32'd0);
        adv();
        idle();
        settle();
        check("lb_data", load_datam, 32'hFFFFFF80);

        // LBU 0x103, same timing
        adv();
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 1'b0, 32'h0);
            settle();
            if (stall_m) stall_cnt++;
            adv();
        end
        check("lbu_stall_cycles", stall_cnt, 32'd3);
        drive(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 1'b1, 32'h80123456);
        adv();
        idle();
        settle();
        check("lbu_data", load_datam, 32'h00000080);

        // SH 0x202
        adv();
        drive(1'b1, 1'b0, 3'b001, 32'h202, 32'h1234ABCD, 1'b1, 32'hFFFFFFFF);
        settle();
        check("sh_addr",  dmem_addr,         32'h200);
        check("sh_be",    {28'd0, dmem_be},  32'hC);
        check("sh_wdata", dmem_wdata,        32'hABCDABCD);
        check("sh_we",    {31'd0, dmem_we},  32'd1);
        adv();
        idle();
        settle();
        check("sh_load_kept", load_datam, 32'h00000080);

        // SB 0x201 and SW 0x204
        adv();
        drive(1'b1, 1'b0, 3'b000, 32'h201, 32'h000000EF, 1'b1, 32'h0);
        settle();
        check("sb_be",    {28'd0, dmem_be}, 32'h2);
        check("sb_wdata", dmem_wdata,       32'hEFEFEFEF);
        adv();
        drive(1'b1, 1'b0, 3'b010, 32'h204, 32'h01020304, 1'b1, 32'h0);
        settle();
        check("sw_be",    {28'd0, dmem_be}, 32'hF);
        check("sw_wdata", dmem_wdata,       32'h01020304);
        check("sw_addr",  dmem_addr,        32'h204);

        // Write priority when both strobes are high
        adv();
        drive(1'b1, 1'b1, 3'b010, 32'h208, 32'h55555555, 1'b1, 32'h0);
        settle();
        check("wr_prio_we", {31'd0, dmem_we}, 32'd1);
        adv();
        idle();
        settle();
        check("wr_prio_load_kept", load_datam, 32'h00000080);

        // LH / LHU upper half, back-to-back with no bubble
        adv();
        drive(1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 1'b1, 32'h80017FFF);
        adv();
        drive(1'b0, 1'b1, 3'b101, 32'h102, 32'h0, 1'b1, 32'h80017FFF);
        settle();
        check("b2b_req",  {31'd0, dmem_req}, 32'd1);
        check("lh_data",  load_datam,        32'hFFFF8001);
        adv();
        drive(1'b0, 1'b1, 3'b001, 32'h100, 32'h0, 1'b1, 32'h80017FFF);
        settle();
        check("lhu_data", load_datam,        32'h00008001);
        adv();
        idle();
        settle();
        check("lh_low_data", load_datam, 32'h00007FFF);

        // Misaligned LW 0x101
        adv();
        drive(1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 1'b0, 32'h0);
        settle();
        check("mis_req",   {31'd0, dmem_req}, 32'd0);
        check("mis_stall", {31'd0, stall_m},  32'd0);
        adv();
        idle();
        settle();
        check("mis_pulse", {31'd0, misalign_m}, 32'd1);
        adv();
        settle();
        check("mis_pulse_end", {31'd0, misalign_m}, 32'd0);
        check("mis_load_kept", load_datam,          32'h00007FFF);

        // Illegal funct3 011 treated as misaligned
        adv();
        drive(1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 1'b1, 32'h12345678);
        settle();
        check("ill_req", {31'd0, dmem_req}, 32'd0);
        adv();
        idle();
        settle();
        check("ill_pulse", {31'd0, misalign_m}, 32'd1);
        check("ill_load_kept", load_datam, 32'h00007FFF);

        // Stray ack while idle
        adv();
        drive(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 32'h99999999);
        settle();
        check("stray_req", {31'd0, dmem_req}, 32'd0);
        adv();
        idle();
        settle();
        check("stray_load_kept", load_datam, 32'h00007FFF);

        // Reset while waiting, then a stray ack
        adv();
        drive(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 1'b0, 32'h0);
        settle();
        check("rstw_stall", {31'd0, stall_m}, 32'd1);
        adv();
        settle();
        check("rstw_wait_req", {31'd0, dmem_req}, 32'd1);
        adv();
        rst = 1'b1;
        idle();
        adv();
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 32'hCAFEF00D);
        settle();
        check("rstw_req",   {31'd0, dmem_req}, 32'd0);
        check("rstw_stall_after", {31'd0, stall_m}, 32'd0);
        adv();
        idle();
        settle();
        check("rstw_load", load_datam, 32'd0);
        check("rstw_buserr", {31'd0, bus_err_m}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
